// File: rtl/buttfly_pkg.sv
// Shared constants, types and state encoding for the butterfly pair feeder.
package buttfly_pkg;

    localparam int W        = 5;
    localparam int OUT_W    = 8;
    localparam int LOG_HALF = 2;
    localparam int HALF     = 1 << LOG_HALF;

    typedef logic [W-1:0]        sample_t;
    typedef logic [OUT_W-1:0]    result_t;
    typedef logic [LOG_HALF-1:0] idx_t;

    // FILL buffers x[0..HALF-1]; PAIR streams x[HALF..2*HALF-1] against them.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        PAIR = 1'b1
    } feed_state_t;

endpackage

// File: rtl/buttfly_half_buf.sv
// Half-frame sample buffer: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module buttfly_half_buf #(
    parameter int W         = buttfly_pkg::W,
    parameter int LOG_DEPTH = buttfly_pkg::LOG_HALF
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LOG_DEPTH-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic [LOG_DEPTH-1:0] raddr,
    output logic [W-1:0]         rdata
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [W-1:0] mem [DEPTH];

    // Store each first-half sample at its frame index.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/buttfly_pair_feeder.sv
// Streaming front-end for the radix-2 butterfly core. Buffers the first half
// of each frame, then pairs every second-half sample with its stored partner,
// presents the pair to the external combinational core, and registers the
// core result into a valid/ready output stream.
//
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds data stable while valid && !ready, and ready may depend
// combinationally on the far side (s_ready follows m_ready in PAIR).
module buttfly_pair_feeder
    import buttfly_pkg::*;
#(
    parameter int W        = buttfly_pkg::W,
    parameter int OUT_W    = buttfly_pkg::OUT_W,
    parameter int LOG_HALF = buttfly_pkg::LOG_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic [W-1:0]     bf_a,
    output logic [W-1:0]     bf_b,
    input  logic [OUT_W-1:0] bf_res,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last,
    output logic             busy
);

    localparam int HALF_N = 1 << LOG_HALF;
    localparam logic [LOG_HALF-1:0] IDX_LAST = LOG_HALF'(HALF_N - 1);

    feed_state_t         state;
    logic [LOG_HALF-1:0] idx;
    logic [W-1:0]        buf_rdata;
    logic                accept;
    logic                idx_at_last;
    logic                pair_live;

    assign accept      = s_valid && s_ready;
    assign idx_at_last = (idx == IDX_LAST);
    assign pair_live   = (state == PAIR) && s_valid;

    // Input readiness: FILL always takes data; PAIR only when the result slot frees.
    always_comb begin
        s_ready = 1'b1;
        if (state == PAIR) begin
            s_ready = !m_valid || m_ready;
        end
    end

    // Core operands are held at zero unless a live pair is on the bus.
    always_comb begin
        bf_a = '0;
        bf_b = '0;
        if (pair_live) begin
            bf_a = buf_rdata;
            bf_b = s_data;
        end
    end

    assign busy = (state == PAIR) || m_valid;

    buttfly_half_buf #(
        .W         (W),
        .LOG_DEPTH (LOG_HALF)
    ) u_half_buf (
        .clk   (clk),
        .we    (accept && (state == FILL)),
        .waddr (idx),
        .wdata (s_data),
        .raddr (idx),
        .rdata (buf_rdata)
    );

    // Frame sequencing: index advances per accept, phase flips at the half boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            idx   <= '0;
        end else if (accept) begin
            idx <= idx + 1'b1;
            if (idx_at_last) begin
                state <= (state == FILL) ? PAIR : FILL;
            end
        end
    end

    // Result register: load on a paired accept, otherwise drain on m_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (accept && (state == PAIR)) begin
            m_valid <= 1'b1;
            m_data  <= bf_res;
            m_last  <= idx_at_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
